accum_sequencer: RTL

Upstream feeder for the 32-bit accumulator stage. Accepts a valid/ready sample stream, buffers it in a small FIFO, and replays it to the accumulator as gap-free 10-beat frames. It drives the accumulator's data, index and clear inputs, and flags the cycle in which the accumulator's result register holds a fresh frame sum. The accumulator has no valid input, so every frame must be presented on consecutive cycles with no bubbles.

---
 rtl/accum_sequencer_pkg.sv | 7 +
 rtl/accum_sequencer_if.sv | 13 +
 rtl/accum_sequencer_sync_fifo.sv | 30 +++
 rtl/accum_sequencer.sv | 53 +++++
 4 files changed

// File: rtl/accum_sequencer_pkg.sv
// accum_pkg: widths, frame length and FSM state type shared with the accumulator.
package accum_pkg;
    localparam int DATA_W    = 32;
    localparam int N_W       = 4;
    localparam int FRAME_LEN = 10;
    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
endpackage

// File: rtl/accum_sequencer_if.sv
// accum_sequencer_if: sample stream in, accumulator drive and frame-done flag out.
interface accum_sequencer_if;
    import accum_pkg::*;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] acc_a;
    logic [N_W-1:0]    acc_n;
    logic              acc_clr;
    logic              y_valid;
    modport master (output in_data, in_valid, input in_ready, acc_a, acc_n, acc_clr, y_valid);
    modport slave  (input in_data, in_valid, output in_ready, acc_a, acc_n, acc_clr, y_valid);
endinterface

// File: rtl/accum_sequencer_sync_fifo.sv
// sync_fifo: single-clock FIFO exposing head data and a registered occupancy count.
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr, rptr;
    assign head = mem[rptr];
    always_ff @(posedge clk)
        if (push) mem[wptr] <= wdata;
    always_ff @(posedge clk)
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(push);
            rptr  <= rptr + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
endmodule

// File: rtl/accum_sequencer.sv
// accum_sequencer: buffers samples and replays them as gap-free frames to the accumulator,
// with one clear/result cycle between frames.
module accum_sequencer #(
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 10
) (
    input  logic               clk,
    input  logic               reset,
    accum_sequencer_if.slave   bus
);
    import accum_pkg::*;
    localparam int CW = $clog2(DEPTH) + 1;
    state_t            state;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] head;
    logic              push, pop, start, last;
    assign bus.in_ready = count < CW'(DEPTH);
    assign push  = bus.in_valid & bus.in_ready;
    // A frame only starts with all its samples already buffered, so RUN never starves.
    assign start = state != RUN && count >= CW'(FRAME_LEN);
    assign last  = bus.acc_n == N_W'(FRAME_LEN - 1);
    assign pop   = start | (state == RUN && !last);
    sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (bus.in_data),
        .head  (head),
        .count (count)
    );
    always_ff @(posedge clk)
        if (reset) begin
            state       <= IDLE;
            bus.acc_a   <= '0;
            bus.acc_n   <= '0;
            bus.acc_clr <= 1'b1;
            bus.y_valid <= 1'b0;
        end else begin
            bus.y_valid <= state == RUN && last;
            if (pop) begin
                state       <= RUN;
                bus.acc_a   <= head;
                bus.acc_n   <= start ? '0 : bus.acc_n + 1'b1;
                bus.acc_clr <= 1'b0;
            end else begin
                state       <= state == RUN ? GAP : IDLE;
                bus.acc_a   <= '0;
                bus.acc_n   <= '0;
                bus.acc_clr <= 1'b1;
            end
        end
endmodule
